// File: rtl/keccak_pkg.sv
// Shared Keccak slice geometry and theta FSM state type, reused by the theta and rho/pi stages.
package keccak_pkg;

  localparam int unsigned SLICE_W    = 25;
  localparam int unsigned NUM_SLICES = 64;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned LANES_X    = 5;
  localparam int unsigned LANES_Y    = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } theta_state_t;

  function automatic int unsigned bit_idx(input int unsigned x, input int unsigned y);
    return LANES_X * y + x;
  endfunction

endpackage

// File: rtl/slice_col_parity.sv
// Combinational column parity of one 25-bit Keccak slice: o_parity[x] = XOR over y of bit (x,y).
module slice_col_parity
  import keccak_pkg::*;
(
  input  logic [SLICE_W-1:0] i_slice,
  output logic [LANES_X-1:0] o_parity
);

  for (genvar x = 0; x < LANES_X; x++) begin : g_col
    assign o_parity[x] = i_slice[bit_idx(x, 0)] ^ i_slice[bit_idx(x, 1)] ^
                         i_slice[bit_idx(x, 2)] ^ i_slice[bit_idx(x, 3)] ^
                         i_slice[bit_idx(x, 4)];
  end

endmodule

// File: rtl/theta_slice_stage.sv
// Keccak theta stage: loads 64 slices with their column parities, then streams theta output.
// Define THETA_PARITY_PORT_EN to expose the stored column parity of the emitted slice.
module theta_slice_stage
  import keccak_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  line_index,
  input  logic [SLICE_W-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_index,
  output logic [SLICE_W-1:0] out_data,
`ifdef THETA_PARITY_PORT_EN
  output logic [LANES_X-1:0] parity_out,
`endif
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LastZ = ADDR_W'(NUM_SLICES - 1);

  theta_state_t       r_state, w_state_next;
  logic [ADDR_W-1:0]  r_cnt, w_cnt_next;
  logic [SLICE_W-1:0] r_buf [NUM_SLICES];
  logic [LANES_X-1:0] r_par [NUM_SLICES];

  logic               w_load_we;
  logic [LANES_X-1:0] w_par_in;
  logic [ADDR_W-1:0]  w_zm1;
  logic [SLICE_W-1:0] w_slice;
  logic [LANES_X-1:0] w_par_z, w_par_zm1, w_d;
  logic [SLICE_W-1:0] w_theta;

  slice_col_parity u_col_parity (
    .i_slice  (data_in),
    .o_parity (w_par_in)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Slice and parity storage needs no reset; it is fully rewritten by every LOAD.
  always_ff @(posedge clk) begin
    if (w_load_we) begin
      r_buf[r_cnt] <= data_in;
      r_par[r_cnt] <= w_par_in;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load_we    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        w_load_we  = 1'b1;
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == LastZ) w_state_next = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == LastZ) w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counter wraps naturally, so z=0 picks up the parity of slice 63.
  assign w_zm1     = r_cnt - 1'b1;
  assign w_slice   = r_buf[r_cnt];
  assign w_par_z   = r_par[r_cnt];
  assign w_par_zm1 = r_par[w_zm1];

  for (genvar x = 0; x < LANES_X; x++) begin : g_d
    assign w_d[x] = w_par_z[(x + LANES_X - 1) % LANES_X] ^ w_par_zm1[(x + 1) % LANES_X];
    for (genvar y = 0; y < LANES_Y; y++) begin : g_y
      assign w_theta[bit_idx(x, y)] = w_slice[bit_idx(x, y)] ^ w_d[x];
    end
  end

  // Outputs derive from the held counter and static buffers, so they stay stable under stall.
  assign line_index = r_cnt;
  assign out_index  = out_valid ? r_cnt : '0;
  assign out_data   = out_valid ? w_theta : '0;

`ifdef THETA_PARITY_PORT_EN
  assign parity_out = out_valid ? w_par_z : '0;
`endif

endmodule

// File: doc/theta_slice_stage.md
Name: theta_slice_stage

Overview:
- Keccak-f theta stage directly downstream of the add-round-constant stage.
- Reads the 64 x 25-bit slice state from the add-RC slice memory by driving its 6-bit line index.
- Computes the 5-bit column parity of every slice, then streams 64 theta-transformed slices to the next stage (rho/pi) over a valid/ready handshake.
- Fully synthesizable; no file I/O.

Parameters:
- SLICE_W, 25, bits per slice; bit index b = 5*y + x (x,y in 0..4). Fixed by the Keccak geometry; any other value is illegal.
- NUM_SLICES, 64, slices per state (lane width); z = line index.
- ADDR_W, 6, width of slice/line index; must equal log2(NUM_SLICES).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: begin processing the state held upstream
- line_index  output  ADDR_W  slice address driven to the upstream memory
- data_in  input  SLICE_W  upstream slice at line_index; combinational, same cycle
- out_valid  output  1  out_data/out_index valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_index  output  ADDR_W  z of the emitted slice
- out_data  output  SLICE_W  theta-transformed slice
- busy  output  1  high in LOAD or EMIT
- done  output  1  one-cycle pulse after the last slice is accepted

Behaviour:
- Reset values: line_index=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0. FSM returns to IDLE, counter=0. Buffer contents are don't-care.
- States:
  - IDLE -> LOAD on start.
  - LOAD -> EMIT after slice 63 is captured.
  - EMIT -> DONE when slice 63 is accepted.
  - DONE -> IDLE unconditionally, 1 cycle, done=1.
- LOAD (64 cycles):
  - line_index = counter.
  - Each cycle, data_in is written to buf[counter] and C[x][counter] = XOR over y of data_in[5y+x] is written to par[counter].
  - Counter wraps 63 -> 0 on exit.
- EMIT: out_valid=1.
  - out_index = counter.
  - out_data bit (x,y) = buf[z][5y+x] ^ par[z][(x+4)%5] ^ par[(z+63)%64][(x+1)%5], with z = counter.
  - z=0 uses par[63] (wrap-around).
  - Counter advances only on out_valid & out_ready. out_data and out_index are held stable while out_ready=0.
- Latency: start sampled at edge 0. LOAD occupies cycles 1..64. First out_valid in cycle 65. With out_ready tied high, done pulses in cycle 129.
- start while busy or in DONE is ignored. start in the same cycle done is high is ignored.
- out_data may be registered or combinational from buf/par, but it must meet the hold-stable rule.
- Reset asserted mid-LOAD or mid-EMIT aborts immediately to the reset values. No partial done.
- Upstream data must be stable from start until LOAD ends. This is the integrator's responsibility and is not checked.

Optional Feature:
- THETA_PARITY_PORT_EN defined:
  - Adds output port parity_out [4:0], equal to par[out_index] while out_valid, else 0. Reset value 0.
  - Used for debug/verification of the column-parity step.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package keccak_pkg holds:
  - SLICE_W, NUM_SLICES, ADDR_W, LANES_X=5, LANES_Y=5.
  - Function bit_idx(x,y)=5*y+x.
  - State enum theta_state_t {IDLE, LOAD, EMIT, DONE}.
  - The same package is reused by the rho/pi stages.
- One natural sub-module, slice_col_parity: combinational, 25-bit slice in, 5-bit column parity out. It is reused by the later parity-check stage.

Test Plan:
- All-zero state; start -> 64 slices out, all out_data=0; done in cycle 129 with out_ready=1.
- Slice 0 = 25'h0000001 (x=0,y=0), rest 0 -> out[0]=25'h0210843, out[1]=25'h1084210, all others 0.
- Slice 63 = 25'h0000001, rest 0 (wrap) -> out[63]=25'h0210843, out[0]=25'h1084210, others 0.
- Random state vs. reference model with out_ready low for 3 cycles at z=17 and z=63 -> out_data/out_index held during stall, all 64 slices match, no slice skipped or duplicated.
- start pulsed at z=10 of LOAD and again in EMIT -> ignored, exactly one done. Then rst asserted at z=30 of EMIT -> all outputs to reset values same cycle, no done. A fresh start then completes correctly.
- THETA_PARITY_PORT_EN build, single-bit test from the second scenario -> parity_out=5'b00001 at out_index 0, 0 elsewhere while out_valid.
